spi_slave_core: RTL and testbench
=================================

Name: spi_slave_core

Overview:
- SPI responder (slave) for the far end of the APB SPI master link. Samples the master's sclk/ss/mosi with PCLK, shifts a full-duplex word in and out in all four CPOL/CPHA modes, and drives miso.
- Exists mainly as the loop-back partner for master/baud-generator verification; also usable as a synthesizable slave peripheral.
- Local side is a simple transmit-load / receive-valid handshake.

Parameters:
- DATA_WIDTH, 8, frame length in bits and width of tx_data/rx_data.
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers on sclk, ss and mosi (minimum 2).

Ports:
- PCLK  in  1  system clock; all logic is on its rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- cpol  in  1  sclk idle level; must be stable while ss is low.
- cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; must be stable while ss is low.
- lsbfe  in  1  1 = LSB first, 0 = MSB first.
- sclk  in  1  serial clock from the master; asynchronous to PCLK.
- ss  in  1  active-low slave select.
- mosi  in  1  serial data in.
- miso  out  1  serial data out.
- miso_oe  out  1  output enable for miso; high only while selected.
- tx_data  in  DATA_WIDTH  word to transmit.
- tx_load  in  1  one-cycle strobe that writes tx_data into the tx buffer.
- tx_ready  out  1  tx buffer empty.
- rx_data  out  DATA_WIDTH  last complete received word.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- rx_ack  in  1  clears the rx_full state.
- overrun  out  1  sticky; set when a word completes while rx_full is still set.
- clr_overrun  in  1  clears overrun.
- busy  out  1  frame in progress.

Behaviour:
- Reset values: miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, overrun=0, busy=0, rx_full=0, state=IDLE.
- Synchronization: sclk, ss and mosi each pass through SYNC_STAGES flops (sclk_s, ss_s, mosi_s). Edge detection compares sclk_s with a one-cycle-delayed copy.
- Edge definitions:
  - leading edge = sclk_s moves away from cpol; trailing edge = sclk_s returns to cpol.
  - sample edge = leading if cpha=0, trailing if cpha=1; shift edge = the other one.
- Master timing requirement: sclk high and low phases are each ≥ 4 PCLK cycles, i.e. master baud divisor ≥ 8.
- Tx buffer:
  - tx_load writes tx_data into the buffer and clears tx_ready. A tx_load while tx_ready=0 overwrites the buffer.
  - At frame start the buffer moves into the shift register and tx_ready returns to 1.
  - If the buffer is empty at frame start, all-zeros are transmitted.
- FSM states: IDLE, ACTIVE, DONE.
- IDLE -> ACTIVE on the ss_s falling edge:
  - load the shift register, clear bit_cnt, set busy=1 and miso_oe=1.
  - cpha=0: first bit (MSB, or LSB if lsbfe) is on miso the cycle after the ss_s fall.
  - cpha=1: miso is driven but the first bit shifts out on the first leading edge.
- ACTIVE:
  - On each sample edge, capture mosi_s into the receive register and increment bit_cnt.
  - On each shift edge, present the next tx bit on miso. For cpha=0 the first leading edge is a sample, not a shift.
  - When bit_cnt reaches DATA_WIDTH on a sample edge, go to DONE.
- DONE (one cycle):
  - rx_data <= assembled word (bit order per lsbfe); rx_valid=1 for this cycle.
  - If rx_full was already set, set overrun; rx_data is still overwritten. Then set rx_full.
  - Go to a wait condition: stay non-busy (busy=0), ignore further sclk edges, and keep miso_oe high until ss_s rises, then go to IDLE.
  - A new frame requires ss to deassert and reassert.
- ss_s rising during ACTIVE: abort the frame. Partial data is discarded, no rx_valid is generated, and the state goes to IDLE with busy=0 and miso_oe=0. The tx word consumed at frame start is not restored.
- Latency: miso changes SYNC_STAGES+1 PCLK cycles after a shift edge at the pin; rx_valid fires SYNC_STAGES+2 cycles after the final sample edge at the pin.
- Simultaneous events:
  - rx_ack and a completion in the same cycle: completion wins (rx_full=1), and overrun is evaluated with the pre-ack rx_full.
  - clr_overrun and an overrun set in the same cycle: set wins.
- PRESET mid-frame: every output returns to its reset value immediately, the FSM goes to IDLE, and the frame is lost.

Test Plan:
- Mode 0 (cpol=0, cpha=0, MSB first), divisor 8: load tx 0xA5, master sends 0x3C -> master receives 0xA5; rx_data=0x3C with one rx_valid pulse; tx_ready=1 after ss falls.
- All four cpol/cpha combinations, lsbfe=1: slave tx 0x81, master sends 0x5A -> correct bit-reversed ordering on both lines in every mode; miso_oe high only while ss is low.
- Two frames without rx_ack (0x11 then 0x22) -> second completion sets overrun=1 and rx_data=0x22; clr_overrun clears it; the same-cycle set-vs-clear case shows set wins.
- ss raised after 4 of 8 bits -> no rx_valid, busy=0, miso_oe=0; the next full frame receives correctly.
- No tx_load before the frame -> miso transmits 0x00; extra sclk pulses after the 8th bit while ss stays low are ignored (no second rx_valid).
- PRESET pulsed mid-frame -> all outputs at reset values within the same cycle; the next frame after release completes normally.

Source files
------------

// File: rtl/spi_slave_core_if.sv
// Signal bundle between the SPI responder and its surroundings: serial pins, mode
// configuration and the local transmit-load / receive-valid handshake.
interface spi_slave_core_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  cpol;
    logic                  cpha;
    logic                  lsbfe;
    logic                  sclk;
    logic                  ss;
    logic                  mosi;
    logic                  miso;
    logic                  miso_oe;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_load;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ack;
    logic                  overrun;
    logic                  clr_overrun;
    logic                  busy;

    modport slave (
        input  cpol, cpha, lsbfe, sclk, ss, mosi, tx_data, tx_load, rx_ack, clr_overrun,
        output miso, miso_oe, tx_ready, rx_data, rx_valid, overrun, busy
    );

    modport master (
        output cpol, cpha, lsbfe, sclk, ss, mosi, tx_data, tx_load, rx_ack, clr_overrun,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid, overrun, busy
    );
endinterface

// File: rtl/spi_slave_core.sv
// SPI responder: oversamples sclk/ss/mosi with PCLK, shifts one full-duplex word per
// frame in any CPOL/CPHA mode and hands the received word over with a valid pulse.
//
// state  | meaning
// IDLE   | deselected, miso released, waiting for ss to fall
// ACTIVE | frame running, sampling and shifting on sclk edges
// DONE   | last bit captured; publish rx_data and pulse rx_valid
// HOLD   | word delivered, ignore sclk, keep driving miso until ss rises
module spi_slave_core #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              PCLK,
    input  logic              PRESET,
    spi_slave_core_if.slave   bus
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE, HOLD} state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0]  ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0]  mosi_sync_q, mosi_sync_d;
    logic                    sclk_prev_q, sclk_prev_d;
    logic                    ss_prev_q, ss_prev_d;
    logic [DATA_WIDTH-1:0]   tx_buf_q, tx_buf_d;
    logic                    tx_ready_q, tx_ready_d;
    logic [DATA_WIDTH-1:0]   tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0]   rx_shift_q, rx_shift_d;
    logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
    logic                    miso_q, miso_d;
    logic                    miso_oe_q, miso_oe_d;
    logic                    busy_q, busy_d;
    logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    rx_full_q, rx_full_d;
    logic                    overrun_q, overrun_d;

    logic                    sclk_s, ss_s, mosi_s;
    logic                    sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
    logic                    ss_fall;
    logic [DATA_WIDTH-1:0]   start_word, start_shifted, tx_shifted, rx_shifted;
    logic                    start_bit, tx_next_bit;

    assign sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
    assign ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], bus.ss};
    assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s        = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_prev_d = sclk_s;
    assign ss_prev_d   = ss_s;

    assign sclk_edge   = sclk_s ^ sclk_prev_q;
    assign lead_edge   = sclk_edge & (sclk_s != bus.cpol);
    assign trail_edge  = sclk_edge & (sclk_s == bus.cpol);
    assign sample_edge = bus.cpha ? trail_edge : lead_edge;
    assign shift_edge  = bus.cpha ? lead_edge : trail_edge;
    assign ss_fall     = ss_prev_q & ~ss_s;

    // An empty buffer at frame start sends all zeros.
    assign start_word    = tx_ready_q ? '0 : tx_buf_q;
    assign start_bit     = bus.lsbfe ? start_word[0] : start_word[DATA_WIDTH-1];
    assign start_shifted = bus.lsbfe ? {1'b0, start_word[DATA_WIDTH-1:1]}
                                     : {start_word[DATA_WIDTH-2:0], 1'b0};
    assign tx_next_bit   = bus.lsbfe ? tx_shift_q[0] : tx_shift_q[DATA_WIDTH-1];
    assign tx_shifted    = bus.lsbfe ? {1'b0, tx_shift_q[DATA_WIDTH-1:1]}
                                     : {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
    assign rx_shifted    = bus.lsbfe ? {mosi_s, rx_shift_q[DATA_WIDTH-1:1]}
                                     : {rx_shift_q[DATA_WIDTH-2:0], mosi_s};

    always_comb begin
        state_d    = state_q;
        tx_buf_d   = tx_buf_q;
        tx_ready_d = tx_ready_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        bit_cnt_d  = bit_cnt_q;
        miso_d     = miso_q;
        miso_oe_d  = miso_oe_q;
        busy_d     = busy_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_full_d  = rx_full_q & ~bus.rx_ack;
        overrun_d  = overrun_q & ~bus.clr_overrun;

        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d    = ACTIVE;
                    tx_ready_d = 1'b1;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    busy_d     = 1'b1;
                    miso_oe_d  = 1'b1;
                    // With cpha=1 the first bit waits for the first leading edge.
                    if (!bus.cpha) begin
                        miso_d     = start_bit;
                        tx_shift_d = start_shifted;
                    end else begin
                        miso_d     = 1'b0;
                        tx_shift_d = start_word;
                    end
                end
            end
            ACTIVE: begin
                if (ss_s) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    miso_oe_d = 1'b0;
                    miso_d    = 1'b0;
                end else begin
                    if (sample_edge) begin
                        rx_shift_d = rx_shifted;
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d = DONE;
                            busy_d  = 1'b0;
                        end
                    end
                    if (shift_edge) begin
                        miso_d     = tx_next_bit;
                        tx_shift_d = tx_shifted;
                    end
                end
            end
            DONE: begin
                rx_data_d  = rx_shift_q;
                rx_valid_d = 1'b1;
                // Completion beats a same-cycle ack and clear; overrun uses the pre-ack flag.
                if (rx_full_q) overrun_d = 1'b1;
                rx_full_d = 1'b1;
                if (ss_s) begin
                    state_d   = IDLE;
                    miso_oe_d = 1'b0;
                    miso_d    = 1'b0;
                end else begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (ss_s) begin
                    state_d   = IDLE;
                    miso_oe_d = 1'b0;
                    miso_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.tx_load) begin
            tx_buf_d   = bus.tx_data;
            tx_ready_d = 1'b0;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= IDLE;
            sclk_sync_q <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b1;
            tx_buf_q    <= '0;
            tx_ready_q  <= 1'b1;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            bit_cnt_q   <= '0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_full_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            ss_sync_q   <= ss_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            ss_prev_q   <= ss_prev_d;
            tx_buf_q    <= tx_buf_d;
            tx_ready_q  <= tx_ready_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            bit_cnt_q   <= bit_cnt_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            busy_q      <= busy_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_full_q   <= rx_full_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.miso     = miso_q;
    assign bus.miso_oe  = miso_oe_q;
    assign bus.tx_ready = tx_ready_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.overrun  = overrun_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: a behavioural SPI master at divisor 8 drives
// frames in all modes and checks both data directions plus the status flags.
module tb_spi_slave_core;
    localparam int H = 4;

    logic PCLK = 1'b0;
    logic PRESET = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   rv_cnt = 0;
    int   rv_before;
    logic [7:0] mrx;
    logic mid_busy, mid_oe, mid_txr;
    bit   race_seen;

    spi_slave_core_if #(.DATA_WIDTH(8)) sif ();

    spi_slave_core #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (sif.slave)
    );

    always #5 PCLK = ~PCLK;

    always @(negedge PCLK) if (sif.rx_valid) rv_cnt <= rv_cnt + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic load_tx(input logic [7:0] v);
        @(negedge PCLK);
        sif.tx_data = v;
        sif.tx_load = 1'b1;
        @(negedge PCLK);
        sif.tx_load = 1'b0;
    endtask

    task automatic pulse_ack();
        @(negedge PCLK);
        sif.rx_ack = 1'b1;
        @(negedge PCLK);
        sif.rx_ack = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge PCLK);
        sif.clr_overrun = 1'b1;
        @(negedge PCLK);
        sif.clr_overrun = 1'b0;
    endtask

    task automatic set_mode(input logic cpol, input logic cpha, input logic lsbfe);
        @(negedge PCLK);
        sif.cpol  = cpol;
        sif.cpha  = cpha;
        sif.lsbfe = lsbfe;
        sif.sclk  = cpol;
        idle(8);
    endtask

    // Master side; samples miso on the sample edge and presents mosi on the shift edge.
    task automatic spi_xfer(input logic [7:0] mtx, input int nbits, input int extra,
                            input bit hold_ss, output logic [7:0] rx);
        int idx;
        rx = '0;
        sif.sclk = sif.cpol;
        sif.ss   = 1'b0;
        idx = sif.lsbfe ? 0 : 7;
        if (!sif.cpha) sif.mosi = mtx[idx];
        idle(2 * H);
        for (int i = 0; i < nbits; i++) begin
            idx = sif.lsbfe ? i : 7 - i;
            if (sif.cpha) sif.mosi = mtx[idx];
            sif.sclk = ~sif.cpol;
            if (!sif.cpha) rx[idx] = sif.miso;
            idle(H);
            if (i == 0) begin
                mid_busy = sif.busy;
                mid_oe   = sif.miso_oe;
                mid_txr  = sif.tx_ready;
            end
            sif.sclk = sif.cpol;
            if (sif.cpha) rx[idx] = sif.miso;
            else if (i + 1 < nbits) sif.mosi = mtx[sif.lsbfe ? i + 1 : 6 - i];
            idle(H);
        end
        for (int e = 0; e < extra; e++) begin
            sif.sclk = ~sif.cpol;
            idle(H);
            sif.sclk = sif.cpol;
            idle(H);
        end
        if (!hold_ss) begin
            sif.ss = 1'b1;
            idle(4 * H);
        end
    endtask

    localparam logic [2:0] T_CFG [7] = '{3'b001, 3'b011, 3'b101, 3'b111, 3'b001, 3'b111, 3'b010};
    localparam logic [7:0] T_TX  [7] = '{8'h81, 8'h81, 8'h81, 8'h81, 8'h1E, 8'h2C, 8'h96};
    localparam logic [7:0] T_RX  [7] = '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h35, 8'hD4, 8'h4B};

    initial begin
        sif.cpol = 1'b0; sif.cpha = 1'b0; sif.lsbfe = 1'b0;
        sif.sclk = 1'b0; sif.ss = 1'b1; sif.mosi = 1'b0;
        sif.tx_data = '0; sif.tx_load = 1'b0; sif.rx_ack = 1'b0; sif.clr_overrun = 1'b0;

        idle(3);
        check_val("rst_miso", sif.miso, 0);
        check_val("rst_miso_oe", sif.miso_oe, 0);
        check_val("rst_tx_ready", sif.tx_ready, 1);
        check_val("rst_rx_data", sif.rx_data, 0);
        check_val("rst_rx_valid", sif.rx_valid, 0);
        check_val("rst_overrun", sif.overrun, 0);
        check_val("rst_busy", sif.busy, 0);
        PRESET = 1'b0;
        idle(4);

        // Mode 0, MSB first
        set_mode(1'b0, 1'b0, 1'b0);
        load_tx(8'hA5);
        check_val("m0_tx_ready_loaded", sif.tx_ready, 0);
        rv_before = rv_cnt;
        spi_xfer(8'h3C, 8, 0, 1'b0, mrx);
        check_val("m0_master_rx", mrx, 8'hA5);
        check_val("m0_rx_data", sif.rx_data, 8'h3C);
        check_val("m0_rx_valid_cnt", rv_cnt - rv_before, 1);
        check_val("m0_tx_ready_mid", mid_txr, 1);
        check_val("m0_busy_mid", mid_busy, 1);
        check_val("m0_oe_mid", mid_oe, 1);
        check_val("m0_oe_after", sif.miso_oe, 0);
        check_val("m0_busy_after", sif.busy, 0);
        check_val("m0_overrun", sif.overrun, 0);
        pulse_ack();

        for (int t = 0; t < 7; t++) begin
            set_mode(T_CFG[t][2], T_CFG[t][1], T_CFG[t][0]);
            load_tx(T_TX[t]);
            rv_before = rv_cnt;
            spi_xfer(T_RX[t], 8, 0, 1'b0, mrx);
            check_val($sformatf("tab%0d_master_rx", t), mrx, T_TX[t]);
            check_val($sformatf("tab%0d_rx_data", t), sif.rx_data, T_RX[t]);
            check_val($sformatf("tab%0d_rx_valid_cnt", t), rv_cnt - rv_before, 1);
            check_val($sformatf("tab%0d_oe_mid", t), mid_oe, 1);
            check_val($sformatf("tab%0d_oe_after", t), sif.miso_oe, 0);
            pulse_ack();
        end

        // Overrun: two completions without ack
        set_mode(1'b0, 1'b0, 1'b0);
        spi_xfer(8'h11, 8, 0, 1'b0, mrx);
        check_val("ovr_first_rx", sif.rx_data, 8'h11);
        check_val("ovr_first_flag", sif.overrun, 0);
        spi_xfer(8'h22, 8, 0, 1'b0, mrx);
        check_val("ovr_second_flag", sif.overrun, 1);
        check_val("ovr_second_rx", sif.rx_data, 8'h22);
        pulse_clr();
        check_val("ovr_cleared", sif.overrun, 0);
        // clr_overrun held through the completion cycle, dropped once rx_valid shows
        race_seen = 1'b0;
        fork
            spi_xfer(8'h33, 8, 0, 1'b0, mrx);
            begin
                sif.clr_overrun = 1'b1;
                for (int k = 0; k < 400 && !race_seen; k++) begin
                    @(negedge PCLK);
                    if (sif.rx_valid) race_seen = 1'b1;
                end
                sif.clr_overrun = 1'b0;
            end
        join
        check_val("race_rx_valid_seen", race_seen, 1);
        check_val("race_set_wins", sif.overrun, 1);
        check_val("race_rx_data", sif.rx_data, 8'h33);
        pulse_clr();
        pulse_ack();

        // Abort after 4 bits, then a full frame
        load_tx(8'h5A);
        rv_before = rv_cnt;
        spi_xfer(8'h96, 4, 0, 1'b0, mrx);
        check_val("abort_rx_valid_cnt", rv_cnt - rv_before, 0);
        check_val("abort_busy", sif.busy, 0);
        check_val("abort_oe", sif.miso_oe, 0);
        check_val("abort_rx_data_kept", sif.rx_data, 8'h33);
        load_tx(8'h6B);
        rv_before = rv_cnt;
        spi_xfer(8'h2D, 8, 0, 1'b0, mrx);
        check_val("post_abort_master_rx", mrx, 8'h6B);
        check_val("post_abort_rx_data", sif.rx_data, 8'h2D);
        check_val("post_abort_rx_valid_cnt", rv_cnt - rv_before, 1);
        pulse_ack();

        // Empty tx buffer and extra sclk pulses while still selected
        rv_before = rv_cnt;
        spi_xfer(8'h77, 8, 3, 1'b0, mrx);
        check_val("empty_master_rx", mrx, 8'h00);
        check_val("extra_rx_valid_cnt", rv_cnt - rv_before, 1);
        check_val("extra_rx_data", sif.rx_data, 8'h77);

        // PRESET mid-frame
        load_tx(8'hFF);
        spi_xfer(8'hC9, 3, 0, 1'b1, mrx);
        load_tx(8'h99);
        check_val("pre_rst_busy", sif.busy, 1);
        check_val("pre_rst_tx_ready", sif.tx_ready, 0);
        @(negedge PCLK);
        PRESET = 1'b1;
        #1;
        check_val("mid_rst_miso", sif.miso, 0);
        check_val("mid_rst_oe", sif.miso_oe, 0);
        check_val("mid_rst_tx_ready", sif.tx_ready, 1);
        check_val("mid_rst_rx_data", sif.rx_data, 0);
        check_val("mid_rst_rx_valid", sif.rx_valid, 0);
        check_val("mid_rst_overrun", sif.overrun, 0);
        check_val("mid_rst_busy", sif.busy, 0);
        sif.ss = 1'b1;
        sif.sclk = sif.cpol;
        idle(4);
        PRESET = 1'b0;
        idle(4);
        load_tx(8'h4E);
        rv_before = rv_cnt;
        spi_xfer(8'hB1, 8, 0, 1'b0, mrx);
        check_val("post_rst_master_rx", mrx, 8'h4E);
        check_val("post_rst_rx_data", sif.rx_data, 8'hB1);
        check_val("post_rst_rx_valid_cnt", rv_cnt - rv_before, 1);
        check_val("post_rst_overrun", sif.overrun, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
